// File: rtl/speculative_issue_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : speculative_issue_controller_if
// Brief    : Pair-input / dual-lane issue bundle for the speculative issue
//            controller. slave = controller side, master = producer/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface speculative_issue_controller_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mc_normal;
    logic [31:0] mc_spec;
    logic [31:0] ins_normal;
    logic [31:0] ins_spec;
    logic        spec_valid;
    logic        flush;
    logic        out_stall;

    logic        out0_valid;
    logic [31:0] out0_mc;
    logic [31:0] out0_ins;
    logic        out1_valid;
    logic [31:0] out1_mc;
    logic [31:0] out1_ins;

    logic [15:0] dual_count;
    logic [15:0] defer_count;
    logic [1:0]  state;

    modport slave (
        input  in_valid, mc_normal, mc_spec, ins_normal, ins_spec,
               spec_valid, flush, out_stall,
        output in_ready, out0_valid, out0_mc, out0_ins,
               out1_valid, out1_mc, out1_ins,
               dual_count, defer_count, state
    );

    modport master (
        output in_valid, mc_normal, mc_spec, ins_normal, ins_spec,
               spec_valid, flush, out_stall,
        input  in_ready, out0_valid, out0_mc, out0_ins,
               out1_valid, out1_mc, out1_ins,
               dual_count, defer_count, state
    );
endinterface
`default_nettype wire

// File: rtl/speculative_issue_controller.sv
`default_nettype none
// ============================================================================
// Module   : speculative_issue_controller
// Brief    : Issues a normal/speculative micro-op pair on two lanes, deferring
//            the speculative op by one slot when it conflicts or depends.
// Revision : 1.0 - initial release
// ============================================================================
module speculative_issue_controller (
    input  logic                          clk,
    input  logic                          rst,
    speculative_issue_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DEFER = 2'b10
    } state_t;

    localparam logic [15:0] c_COUNT_MAX = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_out0_valid, w_out0_valid_nxt;
    logic [31:0] r_out0_mc,    w_out0_mc_nxt;
    logic [31:0] r_out0_ins,   w_out0_ins_nxt;
    logic        r_out1_valid, w_out1_valid_nxt;
    logic [31:0] r_out1_mc,    w_out1_mc_nxt;
    logic [31:0] r_out1_ins,   w_out1_ins_nxt;

    logic [31:0] r_hold_mc,    w_hold_mc_nxt;
    logic [31:0] r_hold_ins,   w_hold_ins_nxt;

    logic [15:0] r_dual_count,  w_dual_count_nxt;
    logic [15:0] r_defer_count, w_defer_count_nxt;

    logic        w_conflict;
    logic        w_dependent;
    logic        w_not_conflict;
    logic        w_in_ready;
    logic        w_accept;

    // Any shared micro-code bit, or a normal op touching the reserved field,
    // forbids co-issue; so does the spec op sourcing the normal op's result.
    always_comb begin
        w_conflict     = (|(bus.mc_spec & bus.mc_normal)) | (|bus.mc_normal[11:5]);
        w_dependent    = (bus.ins_spec[23:16] == bus.ins_normal[7:0]) |
                         (bus.ins_spec[15:8]  == bus.ins_normal[7:0]);
        w_not_conflict = ~(w_conflict | w_dependent);
    end

    assign w_in_ready = (r_state != DEFER) & ~bus.out_stall & ~bus.flush;
    assign w_accept   = bus.in_valid & w_in_ready;

    always_comb begin
        w_state_nxt       = r_state;
        w_out0_valid_nxt  = r_out0_valid;
        w_out0_mc_nxt     = r_out0_mc;
        w_out0_ins_nxt    = r_out0_ins;
        w_out1_valid_nxt  = r_out1_valid;
        w_out1_mc_nxt     = r_out1_mc;
        w_out1_ins_nxt    = r_out1_ins;
        w_hold_mc_nxt     = r_hold_mc;
        w_hold_ins_nxt    = r_hold_ins;
        w_dual_count_nxt  = r_dual_count;
        w_defer_count_nxt = r_defer_count;

        if (bus.flush) begin
            // Flush wins over stall and DEFER; the held op is discarded.
            w_out0_valid_nxt = 1'b0;
            w_out1_valid_nxt = 1'b0;
            w_hold_mc_nxt    = 32'd0;
            w_hold_ins_nxt   = 32'd0;
            w_state_nxt      = IDLE;
        end else if (!bus.out_stall) begin
            case (r_state)
                DEFER: begin
                    w_out0_valid_nxt = 1'b1;
                    w_out0_mc_nxt    = r_hold_mc;
                    w_out0_ins_nxt   = r_hold_ins;
                    w_out1_valid_nxt = 1'b0;
                    w_state_nxt      = ISSUE;
                end
                default: begin
                    if (w_accept) begin
                        w_out0_valid_nxt = 1'b1;
                        w_out0_mc_nxt    = bus.mc_normal;
                        w_out0_ins_nxt   = bus.ins_normal;
                        w_out1_valid_nxt = 1'b0;
                        w_state_nxt      = ISSUE;
                        if (bus.spec_valid && w_not_conflict) begin
                            w_out1_valid_nxt = 1'b1;
                            w_out1_mc_nxt    = bus.mc_spec;
                            w_out1_ins_nxt   = bus.ins_spec;
                            if (r_dual_count != c_COUNT_MAX)
                                w_dual_count_nxt = r_dual_count + 16'd1;
                        end else if (bus.spec_valid) begin
                            w_hold_mc_nxt  = bus.mc_spec;
                            w_hold_ins_nxt = bus.ins_spec;
                            w_state_nxt    = DEFER;
                            if (r_defer_count != c_COUNT_MAX)
                                w_defer_count_nxt = r_defer_count + 16'd1;
                        end
                    end else begin
                        w_out0_valid_nxt = 1'b0;
                        w_out1_valid_nxt = 1'b0;
                        w_state_nxt      = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_out0_valid  <= 1'b0;
            r_out0_mc     <= 32'd0;
            r_out0_ins    <= 32'd0;
            r_out1_valid  <= 1'b0;
            r_out1_mc     <= 32'd0;
            r_out1_ins    <= 32'd0;
            r_hold_mc     <= 32'd0;
            r_hold_ins    <= 32'd0;
            r_dual_count  <= 16'd0;
            r_defer_count <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_out0_valid  <= w_out0_valid_nxt;
            r_out0_mc     <= w_out0_mc_nxt;
            r_out0_ins    <= w_out0_ins_nxt;
            r_out1_valid  <= w_out1_valid_nxt;
            r_out1_mc     <= w_out1_mc_nxt;
            r_out1_ins    <= w_out1_ins_nxt;
            r_hold_mc     <= w_hold_mc_nxt;
            r_hold_ins    <= w_hold_ins_nxt;
            r_dual_count  <= w_dual_count_nxt;
            r_defer_count <= w_defer_count_nxt;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out0_valid  = r_out0_valid;
    assign bus.out0_mc     = r_out0_mc;
    assign bus.out0_ins    = r_out0_ins;
    assign bus.out1_valid  = r_out1_valid;
    assign bus.out1_mc     = r_out1_mc;
    assign bus.out1_ins    = r_out1_ins;
    assign bus.dual_count  = r_dual_count;
    assign bus.defer_count = r_defer_count;
    assign bus.state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_speculative_issue_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_speculative_issue_controller
// Brief    : Directed and randomized bench against a queue-based issue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speculative_issue_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    speculative_issue_controller_if bus ();

    speculative_issue_controller u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] mc;
        logic [31:0] ins;
    } op_t;

    // Reference model: a pending-op queue, the last value per lane, raw counts.
    op_t         m_pending_q[$];
    logic        m_v0, m_v1;
    op_t         m_lane0, m_lane1;
    int          m_dual, m_defer;

    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic bit may_pair(input logic [31:0] mcn, input logic [31:0] mcs,
                                    input logic [31:0] insn, input logic [31:0] inss);
        bit shared_bits = ((mcn & mcs) != 32'd0);
        bit reserved    = (((mcn >> 5) & 32'h7F) != 32'd0);
        bit reads_dest  = (inss[23:16] == insn[7:0]) || (inss[15:8] == insn[7:0]);
        return !(shared_bits || reserved || reads_dest);
    endfunction

    task automatic model_reset();
        m_pending_q.delete();
        m_v0 = 1'b0; m_v1 = 1'b0;
        m_lane0 = '0; m_lane1 = '0;
        m_dual = 0; m_defer = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
        end else if (bus.flush) begin
            m_v0 = 1'b0; m_v1 = 1'b0;
            m_pending_q.delete();
        end else if (bus.out_stall) begin
            // everything frozen
        end else if (m_pending_q.size() != 0) begin
            m_lane0 = m_pending_q.pop_front();
            m_v0 = 1'b1; m_v1 = 1'b0;
        end else if (bus.in_valid) begin
            m_lane0 = '{mc: bus.mc_normal, ins: bus.ins_normal};
            m_v0 = 1'b1; m_v1 = 1'b0;
            if (bus.spec_valid) begin
                if (may_pair(bus.mc_normal, bus.mc_spec, bus.ins_normal, bus.ins_spec)) begin
                    m_lane1 = '{mc: bus.mc_spec, ins: bus.ins_spec};
                    m_v1 = 1'b1;
                    m_dual++;
                end else begin
                    m_pending_q.push_back('{mc: bus.mc_spec, ins: bus.ins_spec});
                    m_defer++;
                end
            end
        end else begin
            m_v0 = 1'b0; m_v1 = 1'b0;
        end
    endtask

    task automatic check_outputs();
        int exp_state;
        exp_state = (m_pending_q.size() != 0) ? 2 : (m_v0 ? 1 : 0);
        check("state",       bus.state,       exp_state);
        check("in_ready",    bus.in_ready,    (m_pending_q.size() == 0) && !bus.out_stall && !bus.flush);
        check("out0_valid",  bus.out0_valid,  m_v0);
        check("out0_mc",     bus.out0_mc,     m_lane0.mc);
        check("out0_ins",    bus.out0_ins,    m_lane0.ins);
        check("out1_valid",  bus.out1_valid,  m_v1);
        check("out1_mc",     bus.out1_mc,     m_lane1.mc);
        check("out1_ins",    bus.out1_ins,    m_lane1.ins);
        check("dual_count",  bus.dual_count,  sat16(m_dual));
        check("defer_count", bus.defer_count, sat16(m_defer));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic set_pair(input logic v, input logic sv,
                            input logic [31:0] mcn, input logic [31:0] mcs,
                            input logic [31:0] insn, input logic [31:0] inss);
        bus.in_valid   = v;
        bus.spec_valid = sv;
        bus.mc_normal  = mcn;
        bus.mc_spec    = mcs;
        bus.ins_normal = insn;
        bus.ins_spec   = inss;
    endtask

    // Reset with a valid pair presented: nothing may be accepted meanwhile.
    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0; bus.out_stall = 1'b0;
        set_pair(1'b1, 1'b1, 32'h1, 32'h2, 32'h05, 32'h0001_0200);
        repeat (2) cycle();
        rst = 1'b0;
        set_pair(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle();
    endtask

    task automatic make_defer(input logic [31:0] spec_ins);
        set_pair(1'b1, 1'b1, 32'h3, 32'h2, 32'h0000_0005, spec_ins);
        cycle();
        set_pair(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [15:0] snap_dual, snap_defer;
        logic [31:0] snap_mc0;
        logic [31:0] r_mcn, r_mcs;

        model_reset();
        bus.flush = 1'b0; bus.out_stall = 1'b0;
        set_pair(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Reset values
        do_reset();
        check("rst_state",  bus.state,      2'b00);
        check("rst_dual",   bus.dual_count, 16'h0);
        check("rst_out0mc", bus.out0_mc,    32'h0);

        // Dual issue
        set_pair(1'b1, 1'b1, 32'h1, 32'h2, 32'h0000_0005, 32'h0001_0200);
        cycle();
        check("dual_v0",    bus.out0_valid, 1'b1);
        check("dual_v1",    bus.out1_valid, 1'b1);
        check("dual_mc1",   bus.out1_mc,    32'h2);
        check("dual_cnt",   bus.dual_count, 16'd1);
        check("dual_state", bus.state,      2'b01);

        // Bit overlap -> DEFER, then the spec op issues on lane 0
        set_pair(1'b1, 1'b1, 32'h3, 32'h2, 32'h0000_0005, 32'h0001_0200);
        cycle();
        check("ovl_v1",    bus.out1_valid,  1'b0);
        check("ovl_state", bus.state,       2'b10);
        check("ovl_defer", bus.defer_count, 16'd1);
        check("ovl_rdy",   bus.in_ready,    1'b0);
        set_pair(1'b1, 1'b0, 32'hAA00_0000, 32'h0, 32'h11, 32'h0);
        cycle();
        check("ovl_mc0",    bus.out0_mc,  32'h2);
        check("ovl_ins0",   bus.out0_ins, 32'h0001_0200);
        check("ovl_state2", bus.state,    2'b01);
        cycle();
        check("ovl_next",   bus.out0_mc,  32'hAA00_0000);

        // Reserved field and dependence both defer
        set_pair(1'b1, 1'b1, 32'h20, 32'h1, 32'h0000_0005, 32'h0001_0200);
        cycle();
        check("rsv_state", bus.state, 2'b10);
        set_pair(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle();
        set_pair(1'b1, 1'b1, 32'h0, 32'h0, 32'h0000_0007, 32'h0000_0700);
        cycle();
        check("dep_state", bus.state, 2'b10);
        set_pair(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle();
        cycle();

        // Stall in DEFER for 3 cycles, then exactly one issue
        do_reset();
        make_defer(32'h0000_0C00);
        bus.out_stall = 1'b1;
        snap_mc0 = bus.out0_mc;
        repeat (3) begin
            cycle();
            check("stl_state", bus.state,    2'b10);
            check("stl_rdy",   bus.in_ready, 1'b0);
            check("stl_mc0",   bus.out0_mc,  snap_mc0);
        end
        bus.out_stall = 1'b0;
        cycle();
        check("stl_rel_mc0",  bus.out0_mc,   32'h2);
        check("stl_rel_ins0", bus.out0_ins,  32'h0000_0C00);
        cycle();
        check("stl_once",     bus.out0_valid, 1'b0);

        // Flush while stalled in DEFER drops the held op
        make_defer(32'h0000_0D00);
        snap_dual  = bus.dual_count;
        snap_defer = bus.defer_count;
        bus.flush = 1'b1; bus.out_stall = 1'b1;
        cycle();
        bus.flush = 1'b0; bus.out_stall = 1'b0;
        check("fl_v0",    bus.out0_valid,  1'b0);
        check("fl_state", bus.state,       2'b00);
        check("fl_dual",  bus.dual_count,  snap_dual);
        check("fl_defer", bus.defer_count, snap_defer);
        repeat (3) begin
            cycle();
            check("fl_never", bus.out0_valid, 1'b0);
        end

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r_mcn = $urandom();
            if ($urandom_range(3) != 0) r_mcn = r_mcn & 32'hFFFF_F01F;
            r_mcs = $urandom();
            if ($urandom_range(1) != 0) r_mcs = r_mcs & ~r_mcn;
            set_pair($urandom_range(9) < 7, $urandom_range(9) < 7, r_mcn, r_mcs,
                     {$urandom_range(255), 8'($urandom_range(3))},
                     {8'($urandom()), 8'($urandom_range(7)), 8'($urandom_range(7)), 8'($urandom())});
            bus.out_stall = ($urandom_range(4) == 0);
            bus.flush     = ($urandom_range(19) == 0);
            cycle();
        end
        bus.out_stall = 1'b0; bus.flush = 1'b0;

        // Saturation of dual_count, then asynchronous reset mid-cycle
        do_reset();
        set_pair(1'b1, 1'b1, 32'h1, 32'h2, 32'h0000_0005, 32'h0001_0200);
        for (int i = 0; i < 65536; i++) cycle();
        check("sat_dual", bus.dual_count, 16'hFFFF);
        repeat (3) cycle();
        check("sat_hold", bus.dual_count, 16'hFFFF);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("arst_v0",   bus.out0_valid, 1'b0);
        check("arst_dual", bus.dual_count, 16'h0);
        check("arst_mc1",  bus.out1_mc,    32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_pair(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
